// File: rtl/sysref_pkg.sv
// Shared types and constants for the SYSREF capture/distribution slice.
package sysref_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } lock_state_t;

   localparam logic MODE_CONT    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/sysref_period_meter.sv
// Rising-edge detector, SYSREF period counter and lock state machine.
module sysref_period_meter
   import sysref_pkg::*;
#(
   parameter int PERIOD_W   = 16,
   parameter int LOCK_COUNT = 4
) (
   input  logic                pl_clk,
   input  logic                pl_rst,
   input  logic                lvl,
   input  logic                lvl_vld,
   input  logic                clr_err,
   output logic                rise,
   output logic [PERIOD_W-1:0] period,
   output logic                locked,
   output logic                err
);

   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

   lock_state_t         state_q, state_d;
   logic                lvl_d_q, vld_d_q;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] ref_q, ref_d;
   logic                ref_vld_q, ref_vld_d;
   logic [MATCH_W-1:0]  match_q, match_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                locked_q, locked_d;
   logic                err_q, err_d;
   logic                sat, meas_match, err_set;
   logic [PERIOD_W-1:0] meas;

   always_comb begin
      // Only a transition between two genuine samples counts, so a level
      // already high when the chain refills after reset is not an edge.
      rise       = lvl & lvl_vld & vld_d_q & ~lvl_d_q;
      sat        = (cnt_q == CNT_MAX);
      meas       = sat ? CNT_MAX : cnt_q + 1'b1;
      meas_match = ref_vld_q && !sat && (meas == ref_q);
      cnt_d      = rise ? '0 : (sat ? cnt_q : cnt_q + 1'b1);

      state_d   = state_q;
      ref_d     = ref_q;
      ref_vld_d = ref_vld_q;
      match_d   = match_q;
      period_d  = period_q;
      err_set   = 1'b0;

      if (rise && state_q != UNLOCKED)
         period_d = meas;

      case (state_q)
         UNLOCKED: begin
            ref_vld_d = 1'b0;
            match_d   = '0;
            if (rise)
               state_d = ACQUIRE;
         end
         ACQUIRE: begin
            if (rise) begin
               if (meas_match) begin
                  match_d = match_q + 1'b1;
                  if (match_q == MATCH_W'(LOCK_COUNT - 1))
                     state_d = LOCKED;
               end else begin
                  ref_d     = meas;
                  ref_vld_d = 1'b1;
                  match_d   = '0;
               end
            end
         end
         LOCKED: begin
            if (sat) begin
               err_set   = 1'b1;
               state_d   = UNLOCKED;
               ref_vld_d = 1'b0;
               match_d   = '0;
            end else if (rise && !meas_match) begin
               err_set   = 1'b1;
               state_d   = ACQUIRE;
               ref_d     = meas;
               ref_vld_d = 1'b1;
               match_d   = '0;
            end
         end
         default: state_d = UNLOCKED;
      endcase

      err_d    = err_set | (err_q & ~clr_err);
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge pl_clk) begin
      if (pl_rst) begin
         state_q   <= UNLOCKED;
         lvl_d_q   <= 1'b0;
         vld_d_q   <= 1'b0;
         cnt_q     <= '0;
         ref_q     <= '0;
         ref_vld_q <= 1'b0;
         match_q   <= '0;
         period_q  <= '0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         lvl_d_q   <= lvl;
         vld_d_q   <= lvl_vld;
         cnt_q     <= cnt_d;
         ref_q     <= ref_d;
         ref_vld_q <= ref_vld_d;
         match_q   <= match_d;
         period_q  <= period_d;
         locked_q  <= locked_d;
         err_q     <= err_d;
      end
   end

   assign period = period_q;
   assign locked = locked_q;
   assign err    = err_q;

endmodule

// File: rtl/sysref_capture_sync.sv
// SYSREF capture chain, period/lock measurement and per-channel fan-out
// with continuous or armed one-shot gating.
module sysref_capture_sync
   import sysref_pkg::*;
#(
   parameter int NUM_CH         = 2,
   parameter int CAPTURE_STAGES = 2,
   parameter int PERIOD_W       = 16,
   parameter int LOCK_COUNT     = 4
) (
   input  logic                pl_clk,
   input  logic                pl_rst,
   input  logic                sysref_in,
   input  logic [NUM_CH-1:0]   mode,
   input  logic [NUM_CH-1:0]   arm,
   input  logic                clr_err,
   output logic [NUM_CH-1:0]   sysref_out,
   output logic [NUM_CH-1:0]   armed,
   output logic                edge_pulse,
   output logic [PERIOD_W-1:0] period,
   output logic                locked,
   output logic                err
);

   logic [CAPTURE_STAGES-1:0] cap_q, cap_d;
   logic [CAPTURE_STAGES-1:0] vld_q, vld_d;
   logic                      edge_pulse_q;
   logic [NUM_CH-1:0]         armed_q, armed_d;
   logic [NUM_CH-1:0]         gate_q, gate_d;
   logic [NUM_CH-1:0]         out_q, out_d;
   logic                      lvl, lvl_vld, rise;

   // vld tracks which capture stages hold real samples since reset.
   always_comb begin
      cap_d[0] = sysref_in;
      vld_d[0] = 1'b1;
      for (int i = 1; i < CAPTURE_STAGES; i++) begin
         cap_d[i] = cap_q[i-1];
         vld_d[i] = vld_q[i-1];
      end
   end

   assign lvl     = cap_q[CAPTURE_STAGES-1];
   assign lvl_vld = vld_q[CAPTURE_STAGES-1];

   sysref_period_meter #(
      .PERIOD_W   (PERIOD_W),
      .LOCK_COUNT (LOCK_COUNT)
   ) u_meter (
      .pl_clk  (pl_clk),
      .pl_rst  (pl_rst),
      .lvl     (lvl),
      .lvl_vld (lvl_vld),
      .clr_err (clr_err),
      .rise    (rise),
      .period  (period),
      .locked  (locked),
      .err     (err)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic oneshot, fire;
         assign oneshot     = (mode[gi] == MODE_ONESHOT);
         // Fire uses armed/locked from before this edge: arming on the edge itself waits for the next one.
         assign fire        = oneshot & armed_q[gi] & locked & rise;
         assign gate_d[gi]  = oneshot & ((gate_q[gi] & lvl) | fire);
         assign armed_d[gi] = (armed_q[gi] & ~fire) | (arm[gi] & oneshot);
         assign out_d[gi]   = (mode[gi] == MODE_CONT) ? lvl : gate_d[gi];
      end
   endgenerate

   always_ff @(posedge pl_clk) begin
      if (pl_rst) begin
         cap_q        <= '0;
         vld_q        <= '0;
         edge_pulse_q <= 1'b0;
         armed_q      <= '0;
         gate_q       <= '0;
         out_q        <= '0;
      end else begin
         cap_q        <= cap_d;
         vld_q        <= vld_d;
         edge_pulse_q <= rise;
         armed_q      <= armed_d;
         gate_q       <= gate_d;
         out_q        <= out_d;
      end
   end

   assign sysref_out = out_q;
   assign armed      = armed_q;
   assign edge_pulse = edge_pulse_q;

endmodule

// File: tb/tb_sysref_capture_sync.sv
// Scoreboard bench: each generated SYSREF edge queues its expected response,
// and a monitor checks it when edge_pulse appears.
module tb_sysref_capture_sync;

   logic        pl_clk = 1'b0;
   logic        pl_rst;
   logic        sysref_in;
   logic [1:0]  mode;
   logic [1:0]  arm;
   logic        clr_err;
   logic [1:0]  sysref_out;
   logic [1:0]  armed;
   logic        edge_pulse;
   logic [15:0] period;
   logic        locked;
   logic        err;

   typedef struct {
      int          cyc;
      logic [15:0] per;
      logic        lck;
      logic        er;
      logic        c1;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   ch1_hi = 0;

   sysref_capture_sync #(
      .NUM_CH         (2),
      .CAPTURE_STAGES (2),
      .PERIOD_W       (16),
      .LOCK_COUNT     (4)
   ) dut (
      .pl_clk     (pl_clk),
      .pl_rst     (pl_rst),
      .sysref_in  (sysref_in),
      .mode       (mode),
      .arm        (arm),
      .clr_err    (clr_err),
      .sysref_out (sysref_out),
      .armed      (armed),
      .edge_pulse (edge_pulse),
      .period     (period),
      .locked     (locked),
      .err        (err)
   );

   always #5 pl_clk = ~pl_clk;
   always @(posedge pl_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops one expectation per edge_pulse.
   always @(negedge pl_clk) begin
      if (edge_pulse === 1'b1) begin
         if (q.size() == 0) begin
            check("spurious_edge", 32'd1, 32'd0);
         end else begin
            mon_e = q.pop_front();
            check("edge_latency", cyc, mon_e.cyc + 3);
            check("period", {16'd0, period}, {16'd0, mon_e.per});
            check("locked", {31'd0, locked}, {31'd0, mon_e.lck});
            check("err", {31'd0, err}, {31'd0, mon_e.er});
            check("ch0_out", {31'd0, sysref_out[0]}, 32'd1);
            check("ch1_out", {31'd0, sysref_out[1]}, {31'd0, mon_e.c1});
            $display("edge at cycle %0d: period=%0d locked=%0b err=%0b out=%b",
                     cyc, period, locked, err, sysref_out);
         end
      end
      if (sysref_out[1] === 1'b1) begin
         ch1_hi++;
         check("ch_align", {31'd0, sysref_out[0]}, 32'd1);
      end
   end

   // One SYSREF window of len cycles (4 high); act selects a quiet-cycle action/check.
   task automatic pulse(input int len, input logic [15:0] ep, input logic el, input logic ee,
                        input logic ec1, input bit arm_rise, input int act);
      exp_t e;
      @(posedge pl_clk); #1;
      sysref_in = 1'b1;
      e.cyc = cyc; e.per = ep; e.lck = el; e.er = ee; e.c1 = ec1;
      q.push_back(e);
      for (int i = 1; i < len; i++) begin
         @(posedge pl_clk); #1;
         if (i == 4) sysref_in = 1'b0;
         if (arm_rise && i == 2) arm = 2'b10;
         if (arm_rise && i == 3) arm = 2'b00;
         if (i == 16 && act == 1) arm = 2'b10;
         if (i == 16 && act == 2) clr_err = 1'b1;
         if (i == 17) begin arm = 2'b00; clr_err = 1'b0; end
         if (i == 18) begin
            case (act)
               1, 6: check("armed_set", {30'd0, armed}, 32'd2);
               2:    check("err_cleared", {31'd0, err}, 32'd0);
               4:    check("armed_clear", {30'd0, armed}, 32'd0);
               5:    check("ch1_one_pulse", ch1_hi, 32'd4);
               7:    check("ch1_two_pulses", ch1_hi, 32'd8);
               default: ;
            endcase
         end
         if (act == 3 && i == len - 2) begin
            check("sat_locked", {31'd0, locked}, 32'd0);
            check("sat_err", {31'd0, err}, 32'd1);
         end
      end
   endtask

   initial begin
      pl_rst = 1'b1; sysref_in = 1'b0; mode = 2'b10; arm = 2'b00; clr_err = 1'b0;
      repeat (3) @(posedge pl_clk);
      #1;
      check("rst_out", {30'd0, sysref_out}, 32'd0);
      check("rst_armed", {30'd0, armed}, 32'd0);
      check("rst_edge", {31'd0, edge_pulse}, 32'd0);
      check("rst_period", {16'd0, period}, 32'd0);
      check("rst_locked", {31'd0, locked}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      pl_rst = 1'b0;
      repeat (3) @(posedge pl_clk);

      // Acquisition: ref edge, store, four matches -> lock on edge 6.
      pulse(32, 16'd0,  0, 0, 0, 0, 0);
      pulse(32, 16'd32, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) pulse(32, 16'd32, 0, 0, 0, 0, 0);
      pulse(32, 16'd32, 1, 0, 0, 0, 0);
      // One-shot on ch1: arm in a quiet cycle, fire once, then idle.
      pulse(32, 16'd32, 1, 0, 0, 0, 1);
      pulse(32, 16'd32, 1, 0, 1, 0, 4);
      pulse(32, 16'd32, 1, 0, 0, 0, 5);
      // Arm coincident with a rise: fires on the following edge.
      pulse(32, 16'd32, 1, 0, 0, 1, 6);
      pulse(33, 16'd32, 1, 0, 1, 0, 4);
      // Period 33 breaks lock; relock after new ref plus four matches.
      pulse(32, 16'd33, 0, 1, 0, 0, 7);
      pulse(32, 16'd32, 0, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) pulse(32, 16'd32, 0, 1, 0, 0, 0);
      pulse(32, 16'd32, 1, 1, 0, 0, 2);
      // SYSREF loss: counter saturates while locked.
      pulse(65600, 16'd32, 1, 0, 0, 0, 3);
      pulse(32, 16'd32, 0, 1, 0, 0, 0);

      // Reset in the middle of a high pulse.
      @(posedge pl_clk); #1;
      sysref_in = 1'b1;
      mon_e.cyc = cyc; mon_e.per = 16'd32; mon_e.lck = 1'b0; mon_e.er = 1'b1; mon_e.c1 = 1'b0;
      q.push_back(mon_e);
      repeat (4) @(posedge pl_clk);
      #1 pl_rst = 1'b1;
      @(posedge pl_clk); #1;
      check("midrst_out", {30'd0, sysref_out}, 32'd0);
      check("midrst_armed", {30'd0, armed}, 32'd0);
      check("midrst_edge", {31'd0, edge_pulse}, 32'd0);
      check("midrst_period", {16'd0, period}, 32'd0);
      check("midrst_locked", {31'd0, locked}, 32'd0);
      check("midrst_err", {31'd0, err}, 32'd0);
      pl_rst = 1'b0;
      repeat (20) @(posedge pl_clk);
      #1 sysref_in = 1'b0;
      repeat (8) @(posedge pl_clk);
      pulse(32, 16'd0, 0, 0, 0, 0, 0);
      repeat (8) @(posedge pl_clk);
      check("pending_edges", q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
